// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Optional edge counters are enabled with MULTI_EDGE_DETECTOR_CNT_EN.
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Upper bound on channels the mode helper can address.
  localparam int MAX_CH = 64;

  // Pull channel ch's 2-bit mode field out of a packed mode vector.
  function automatic edge_mode_t chan_mode(input logic [2*MAX_CH-1:0] modes,
                                           input int ch);
    return edge_mode_t'(modes[2*ch +: 2]);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, glitch filter, rise/fall pulses,
// mode-qualified event, sticky flag and (with MULTI_EDGE_DETECTOR_CNT_EN)
// a saturating event counter.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter logic RST_VAL     = 1'b1
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  ,
  parameter int   CNT_W       = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  edge_mode_t mode,
  input  logic       clr,
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  output logic [CNT_W-1:0] edge_cnt,
`endif
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       evt,
  output logic       evt_flag,
  output logic       flag_nxt
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [FW-1:0]          filt_cnt;
  logic [1:0]             mode_bits;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign mode_bits = mode;

  // Synchroniser shift chain; reset to the idle level so reset creates no edge.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{RST_VAL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Glitch filter: level follows sync_out only after FILTER_LEN consecutive
  // mismatching samples; rise/fall are registered on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt <= '0;
      level    <= RST_VAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_out == level) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        level    <= sync_out;
        rise     <= sync_out;
        fall     <= ~sync_out;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Event uses the live mode so a mode change is seen without delay.
  always_comb begin
    evt      = (rise & mode_bits[0]) | (fall & mode_bits[1]);
    flag_nxt = evt | (evt_flag & ~clr);
  end

  // Sticky flag; a coincident set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) evt_flag <= 1'b0;
    else     evt_flag <= flag_nxt;
  end

`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating event counter; clear with a simultaneous event restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (clr) begin
      edge_cnt <= evt ? CNT_W'(1) : '0;
    end else if (evt && (edge_cnt != CNT_MAX)) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: one edge_det_chan per input plus the
// aggregated any_evt flag. Define MULTI_EDGE_DETECTOR_CNT_EN to add the
// per-channel edge_cnt output.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int   NUM_CH      = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter logic RST_VAL     = 1'b1,
  parameter int   CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     din,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     clr,
  output logic [NUM_CH-1:0]     level,
  output logic [NUM_CH-1:0]     rise,
  output logic [NUM_CH-1:0]     fall,
  output logic [NUM_CH-1:0]     evt,
  output logic [NUM_CH-1:0]     evt_flag,
  output logic                  any_evt
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt
`endif
);

  logic [2*MAX_CH-1:0] mode_ext;
  logic [NUM_CH-1:0]   flag_nxt;

  // Widen the mode vector to the helper's fixed argument width.
  always_comb begin
    mode_ext                 = '0;
    mode_ext[2*NUM_CH-1:0]   = mode;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RST_VAL     (RST_VAL)
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
      ,
      .CNT_W       (CNT_W)
`endif
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .din      (din[g]),
      .mode     (chan_mode(mode_ext, g)),
      .clr      (clr[g]),
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
      .edge_cnt (edge_cnt[g*CNT_W +: CNT_W]),
`endif
      .level    (level[g]),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .evt      (evt[g]),
      .evt_flag (evt_flag[g]),
      .flag_nxt (flag_nxt[g])
    );
  end

`ifndef MULTI_EDGE_DETECTOR_CNT_EN
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

  // any_evt registered from next-state flags so it lines up with evt_flag.
  always_ff @(posedge clk) begin
    if (rst) any_evt <= 1'b0;
    else     any_evt <= |flag_nxt;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector (NUM_CH=2, SYNC_STAGES=2,
// FILTER_LEN=3, CNT_W=2). Edge events are predicted into a scoreboard when
// din is driven and popped by a monitor when the DUT pulses.
module tb_multi_edge_detector;

  localparam int NUM_CH = 2;
  localparam int SYNC   = 2;
  localparam int FILT   = 3;
  localparam int CNT_W  = 2;
  localparam int LAT    = SYNC + FILT;

  logic                clk;
  logic                rst;
  logic [NUM_CH-1:0]   din;
  logic [2*NUM_CH-1:0] mode;
  logic [NUM_CH-1:0]   clr;
  logic [NUM_CH-1:0]   level;
  logic [NUM_CH-1:0]   rise;
  logic [NUM_CH-1:0]   fall;
  logic [NUM_CH-1:0]   evt;
  logic [NUM_CH-1:0]   evt_flag;
  logic                any_evt;
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  logic [NUM_CH*CNT_W-1:0] edge_cnt;
`endif

  multi_edge_detector #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC),
    .FILTER_LEN  (FILT),
    .RST_VAL     (1'b1),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .mode     (mode),
    .clr      (clr),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .evt      (evt),
    .evt_flag (evt_flag),
    .any_evt  (any_evt)
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
    ,
    .edge_cnt (edge_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   e_cyc;
    int   ch;
    logic is_rise;
    logic ev;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Predict an edge on channel ch, LAT edges after din is first sampled.
  task automatic push_edge(input int ch, input logic is_rise);
    exp_t e;
    e.e_cyc   = cyc + LAT;
    e.ch      = ch;
    e.is_rise = is_rise;
    e.ev      = is_rise ? mode[2*ch] : mode[2*ch+1];
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    check_val("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_cyc(input int tgt);
    int n = 0;
    while (cyc != tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_cyc", 32'(cyc), 32'(tgt));
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check_val("rst_quiet", 32'({rise, fall, evt_flag, any_evt}), 32'd0);
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (rise[ch] | fall[ch]) begin
          if (sb.size() == 0) begin
            check_val("spurious", 32'({rise[ch], fall[ch]}), 32'd0);
          end else begin
            e = sb.pop_front();
            check_val("edge_cyc", 32'(cyc), 32'(e.e_cyc));
            check_val("edge_ch", 32'(ch), 32'(e.ch));
            check_val("edge_dir", 32'({rise[ch], fall[ch]}), 32'({e.is_rise, ~e.is_rise}));
            check_val("edge_evt", 32'(evt[ch]), 32'(e.ev));
          end
        end else begin
          check_val("evt_idle", 32'(evt[ch]), 32'd0);
        end
      end
    end
  end

  initial begin
    int tgt;
    rst  = 1'b1;
    din  = '0;
    mode = '0;
    clr  = '0;

    // Reset with din low: both channels fall once after release.
    repeat (3) @(negedge clk);
    check_val("rst_level", 32'(level), 32'h3);
    check_val("rst_any", 32'(any_evt), 32'd0);
    rst = 1'b0;
    push_edge(0, 1'b0);
    push_edge(1, 1'b0);
    drain();
    check_val("post_rst_level", 32'(level), 32'h0);

    // Latency on channel 0, channel 1 left alone.
    din[0] = 1'b1; push_edge(0, 1'b1);
    drain();
    din[0] = 1'b0; push_edge(0, 1'b0);
    drain();
    check_val("lat_level", 32'(level), 32'h0);

    // Glitch filtering on channel 1.
    din[1] = 1'b1; push_edge(1, 1'b1);
    drain();
    din[1] = 1'b0;
    repeat (2) @(negedge clk);
    din[1] = 1'b1;
    repeat (10) @(negedge clk);
    check_val("glitch_level", 32'(level), 32'h2);
    din[1] = 1'b0; push_edge(1, 1'b0);
    repeat (3) @(negedge clk);
    din[1] = 1'b1; push_edge(1, 1'b1);
    drain();
    check_val("pulse3_level", 32'(level), 32'h2);

    // Modes: rising only, then both.
    mode = 4'b0001;
    din[0] = 1'b1; push_edge(0, 1'b1);
    drain();
    din[0] = 1'b0; push_edge(0, 1'b0);
    drain();
    check_val("flag_rise", 32'(evt_flag), 32'h1);
    check_val("any_rise", 32'(any_evt), 32'd1);
    mode = 4'b0011;
    din[0] = 1'b1; push_edge(0, 1'b1);
    drain();
    din[0] = 1'b0; push_edge(0, 1'b0);
    drain();

    // Flag clear, then clear coinciding with an event.
    clr = 2'b01;
    @(negedge clk);
    check_val("clr_flag", 32'(evt_flag), 32'h0);
    check_val("clr_any", 32'(any_evt), 32'd0);
    clr = 2'b00;
    din[0] = 1'b1; push_edge(0, 1'b1);
    tgt = cyc + LAT;
    wait_cyc(tgt);
    clr = 2'b01;
    @(negedge clk);
    check_val("set_wins_flag", 32'(evt_flag), 32'h1);
    check_val("set_wins_any", 32'(any_evt), 32'd1);
    @(negedge clk);
    check_val("clr_only_flag", 32'(evt_flag), 32'h0);
    check_val("clr_only_any", 32'(any_evt), 32'd0);
    clr = 2'b00;

`ifdef MULTI_EDGE_DETECTOR_CNT_EN
    // Counter saturation and clear-with-event.
    clr = 2'b01;
    @(negedge clk);
    clr = 2'b00;
    check_val("cnt_clr", 32'(edge_cnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      din[0] = ~din[0]; push_edge(0, din[0]);
      drain();
    end
    check_val("cnt_sat", 32'(edge_cnt[CNT_W-1:0]), 32'd3);
    check_val("cnt_ch1", 32'(edge_cnt[2*CNT_W-1:CNT_W]), 32'd0);
    din[0] = ~din[0]; push_edge(0, din[0]);
    tgt = cyc + LAT;
    wait_cyc(tgt);
    clr = 2'b01;
    @(negedge clk);
    check_val("cnt_clr_evt", 32'(edge_cnt[CNT_W-1:0]), 32'd1);
    clr = 2'b00;
`endif

    repeat (5) @(negedge clk);
    #1;
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
